// File: rtl/temp_bcd_conv_pkg.sv
// Shared constants, state encoding and the x625 scaling helper for the
// DS18B20 temperature-to-BCD converter.
package temp_bcd_conv_pkg;

  localparam int DATA_W = 16;
  localparam int BIN_W  = 21;
  localparam int DIGITS = 7;
  localparam int MAG_W  = 11;
  localparam int CNT_W  = $clog2(BIN_W);

  // DS18B20 resolution, shared with the 1-Wire master
  localparam int DS_RES_BITS  = 12;
  localparam int DS_FRAC_BITS = 4;

  localparam logic [DATA_W-1:0] MAG_MAX_POS = 16'd2000;
  localparam logic [DATA_W-1:0] MAG_MAX_NEG = 16'd880;
  localparam int                FRAC_MUL    = 625;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // mag * 625 as a shift-add sum: 512 + 64 + 32 + 16 + 1
  function automatic logic [BIN_W-1:0] scale_frac(input logic [MAG_W-1:0] mag);
    logic [BIN_W-1:0] m;
    m = BIN_W'(mag);
    return (m << 9) + (m << 6) + (m << 5) + (m << 4) + m;
  endfunction

endpackage

// File: rtl/temp_bcd_conv_bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to a BCD nibble of 5 or more so the
// following left shift carries correctly into the next decade.
module bcd_digit_adj (
  input  logic [3:0] digit,
  output logic [3:0] adj
);

  assign adj = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule

// File: rtl/temp_bcd_conv.sv
// Converts a raw DS18B20 temperature word into sign + 7 BCD digits (XXX.XXXX degC)
// by scaling the magnitude by 625 and running a one-bit-per-clock double-dabble.
module temp_bcd_conv
  import temp_bcd_conv_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_W-1:0]     din,
  input  logic                  din_vld,
  output logic                  busy,
  output logic                  dout_sign,
  output logic [4*DIGITS-1:0]   dout_bcd,
  output logic                  dout_err,
  output logic                  dout_vld
);

  state_t state, state_next;

  logic [DATA_W-1:0]       raw_q;
  logic [DATA_W-1:0]       pend_q;
  logic                    pend_vld;
  logic [BIN_W-1:0]        bin_q;
  logic [4*DIGITS-1:0]     bcd_q;
  logic [4*DIGITS-1:0]     bcd_adj;
  logic [CNT_W-1:0]        cnt_q;
  logic                    sign_q;
  logic                    err_q;

  logic                    sign_c;
  logic                    err_c;
  logic [DATA_W-1:0]       neg_raw;
  logic [MAG_W-1:0]        mag;
  logic [DATA_W-MAG_W-1:0] hi;
  logic [4*DIGITS+BIN_W-1:0] shift_c;
  logic                    cnt_last;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_adj
      bcd_digit_adj u_adj (
        .digit (bcd_q[4*gi +: 4]),
        .adj   (bcd_adj[4*gi +: 4])
      );
    end
  endgenerate

  // Range is checked on the full-width magnitude so that words like 0xF800,
  // whose 11-bit magnitude wraps to zero, are still flagged.
  always_comb begin
    sign_c  = raw_q[DATA_W-1];
    neg_raw = ~raw_q + 16'd1;
    hi      = raw_q[DATA_W-1:MAG_W];
    mag     = sign_c ? neg_raw[MAG_W-1:0] : raw_q[MAG_W-1:0];
    err_c   = !((&hi) || !(|hi)) ||
              (sign_c ? (neg_raw > MAG_MAX_NEG) : (raw_q > MAG_MAX_POS));
  end

  assign shift_c  = {bcd_adj, bin_q} << 1;
  assign cnt_last = (cnt_q == CNT_W'(BIN_W - 1));
  assign busy     = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (din_vld) state_next = S_LOAD;
      S_LOAD:  state_next = S_SHIFT;
      S_SHIFT: if (cnt_last) state_next = S_DONE;
      S_DONE:  state_next = (din_vld || pend_vld) ? S_LOAD : S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raw_q     <= '0;
      pend_q    <= '0;
      pend_vld  <= 1'b0;
      bin_q     <= '0;
      bcd_q     <= '0;
      cnt_q     <= '0;
      sign_q    <= 1'b0;
      err_q     <= 1'b0;
      dout_sign <= 1'b0;
      dout_bcd  <= '0;
      dout_err  <= 1'b0;
      dout_vld  <= 1'b0;
    end else begin
      dout_vld <= (state == S_DONE);
      case (state)
        S_IDLE: begin
          if (din_vld) raw_q <= din;
        end
        S_LOAD: begin
          sign_q <= sign_c;
          err_q  <= err_c;
          bin_q  <= scale_frac(mag);
          bcd_q  <= '0;
          cnt_q  <= '0;
          if (din_vld) begin
            pend_q   <= din;
            pend_vld <= 1'b1;
          end
        end
        S_SHIFT: begin
          bcd_q <= shift_c[4*DIGITS+BIN_W-1:BIN_W];
          bin_q <= shift_c[BIN_W-1:0];
          cnt_q <= cnt_q + 1'b1;
          if (din_vld) begin
            pend_q   <= din;
            pend_vld <= 1'b1;
          end
          if (cnt_last) begin
            dout_err  <= err_q;
            dout_sign <= sign_q & ~err_q;
            dout_bcd  <= err_q ? '0 : shift_c[4*DIGITS+BIN_W-1:BIN_W];
          end
        end
        S_DONE: begin
          // A strobe arriving in DONE is newer than anything pending
          if (din_vld)       raw_q <= din;
          else if (pend_vld) raw_q <= pend_q;
          pend_vld <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
